// File: rtl/data_memory_responder.sv
// data_memory_responder: responder end of the memory-stage data access interface.
// Accepts one load/store at a time, waits WAIT_STATES cycles, then commits the
// access against an internal word-addressed RAM and pulses resp_valid for one cycle.
// busy stays high from acceptance through the response cycle so the pipeline stalls.
module data_memory_responder #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_was_write
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              wait_cnt;
    logic                    cap_we;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    logic                    accept;
    logic                    enter_resp;
    logic                    access_we;
    logic [ADDR_WIDTH-1:0]   access_addr;
    logic [DATA_WIDTH-1:0]   access_wdata;

    assign accept     = (state == ST_IDLE) && req_valid;
    assign enter_resp = (next_state == ST_RESP);

    // With zero wait states the access completes on the acceptance edge itself,
    // before the capture registers hold the request, so take it from the inputs then.
    assign access_we    = (state == ST_IDLE) ? req_we    : cap_we;
    assign access_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
    assign access_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;

    // Status outputs decode registered state only.
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    // Next-state decode: IDLE -> WAIT/RESP on request, WAIT counts down, RESP -> IDLE.
    always_comb begin
        // NOTE: default assigned first so every path drives next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE: if (req_valid) next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (wait_cnt == 4'd1) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State register, wait counter and request capture.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                wait_cnt  <= 4'(WAIT_STATES);
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // RAM commit and response data, updated on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the RAM is cleared on reset, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
            resp_rdata     <= '0;
            resp_was_write <= 1'b0;
        end else if (enter_resp) begin
            resp_was_write <= access_we;
            if (access_we) begin
                ram[access_addr] <= access_wdata;
                resp_rdata       <= access_wdata;
            end else begin
                resp_rdata <= ram[access_addr];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states) are checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_data_memory_responder;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          v    [2];
    logic          we   [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd   [2];
    logic          busy [2];
    logic          rvld [2];
    logic          wasw [2];
    logic [DW-1:0] rd   [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model state: cycles of busy remaining, pending response, expected RAM.
    int            ws       [2] = '{2, 0};
    int            cyc_left [2];
    logic [DW-1:0] mem      [2][64];
    logic [DW-1:0] pend     [2];
    logic          pend_w   [2];
    logic [DW-1:0] exp_rd   [2];
    logic          exp_w    [2];

    data_memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(v[0]), .req_we(we[0]), .req_addr(addr[0]),
        .req_wdata(wd[0]), .busy(busy[0]), .resp_valid(rvld[0]), .resp_rdata(rd[0]),
        .resp_was_write(wasw[0])
    );

    data_memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v[1]), .req_we(we[1]), .req_addr(addr[1]),
        .req_wdata(wd[1]), .busy(busy[1]), .resp_valid(rvld[1]), .resp_rdata(rd[1]),
        .resp_was_write(wasw[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted request keeps the responder busy for ws+1
    // cycles and responds in the last one; the RAM effect is applied at acceptance
    // since nothing else can touch the RAM before the response.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                cyc_left[i] = 0;
                exp_rd[i]   = '0;
                exp_w[i]    = 1'b0;
                for (int j = 0; j < 64; j++) mem[i][j] = '0;
            end else if (cyc_left[i] == 0) begin
                if (v[i]) begin
                    pend_w[i] = we[i];
                    pend[i]   = we[i] ? wd[i] : mem[i][addr[i]];
                    if (we[i]) mem[i][addr[i]] = wd[i];
                    cyc_left[i] = ws[i] + 1;
                end
            end else begin
                cyc_left[i] = cyc_left[i] - 1;
            end
            if (cyc_left[i] == 1) begin
                exp_rd[i] = pend[i];
                exp_w[i]  = pend_w[i];
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("busy[%0d]", i), busy[i], cyc_left[i] > 0);
                check($sformatf("resp_valid[%0d]", i), rvld[i], cyc_left[i] == 1);
                check($sformatf("resp_rdata[%0d]", i), rd[i], exp_rd[i]);
                check($sformatf("resp_was_write[%0d]", i), wasw[i], exp_w[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to an idle instance and return its response (bounded wait).
    task automatic do_req(input int s, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] r, output logic ww);
        bit seen;
        seen = 0;
        r    = '0;
        ww   = 1'b0;
        v[s] = 1'b1; we[s] = w; addr[s] = a; wd[s] = d;
        tick();
        v[s] = 1'b0;
        for (int k = 0; k < 24 && !seen; k++) begin
            @(negedge clk);
            if (rvld[s]) begin
                seen = 1;
                r    = rd[s];
                ww   = wasw[s];
            end
        end
        check($sformatf("resp_seen[%0d]", s), seen, 1);
        tick();
    endtask

    task automatic load_check(input int s, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                              input string name);
        logic [DW-1:0] r;
        logic          ww;
        do_req(s, 1'b0, a, '0, r, ww);
        check(name, r, exp);
        check({name, "_was_write"}, ww, 0);
    endtask

    initial begin
        logic [DW-1:0] r;
        logic          ww;
        int            pulses;
        int            loads;
        logic [DW-1:0] e;

        // Reset held for two cycles with requests present.
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b1; we[i] = 1'b1; addr[i] = 6'd5; wd[i] = 16'hFFFF;
        end
        repeat (2) begin
            @(posedge clk); #1;
            chk_en = 1;
            @(negedge clk);
            check("rst_busy", busy[0], 0);
            check("rst_resp_valid", rvld[0], 0);
            check("rst_rdata", rd[0], 16'h0000);
        end
        v[0] = 1'b0; v[1] = 1'b0;
        rst = 1'b1;
        tick();
        load_check(0, 6'd5, 16'h0000, "rst_load5");

        // Store 0xBEEF to addr 3 with cycle-exact timing; inputs wander while busy.
        v[0] = 1'b1; we[0] = 1'b1; addr[0] = 6'd3; wd[0] = 16'hBEEF;
        tick();
        v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addr[0] = AW'($urandom);
            wd[0]   = DW'($urandom);
            we[0]   = 1'($urandom);
            @(negedge clk);
            check($sformatf("st_busy_c%0d", k + 1), busy[0], k < 3);
            check($sformatf("st_valid_c%0d", k + 1), rvld[0], k == 2);
            if (k == 2) begin
                check("st_rdata", rd[0], 16'hBEEF);
                check("st_was_write", wasw[0], 1);
            end
        end
        tick();
        load_check(0, 6'd3, 16'hBEEF, "ld3_after_store");

        // Zero wait states: response in the cycle right after acceptance.
        v[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'd5; wd[1] = 16'h0;
        tick();
        v[1] = 1'b0;
        @(negedge clk);
        check("z_busy_c1", busy[1], 1);
        check("z_valid_c1", rvld[1], 1);
        check("z_rdata", rd[1], 16'h0000);
        @(negedge clk);
        check("z_busy_c2", busy[1], 0);
        check("z_valid_c2", rvld[1], 0);
        tick();
        do_req(1, 1'b1, 6'd9, 16'h5A5A, r, ww);
        check("z_st_rdata", r, 16'h5A5A);
        check("z_st_was_write", ww, 1);
        load_check(1, 6'd9, 16'h5A5A, "z_ld9");

        // Store to addr 7 while address/data inputs change every busy cycle.
        v[0] = 1'b1; we[0] = 1'b1; addr[0] = 6'd7; wd[0] = 16'h1234;
        tick();
        v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr[0] = AW'($urandom);
            wd[0]   = DW'($urandom);
            @(negedge clk);
        end
        tick();
        for (int a = 0; a < 64; a++) begin
            e = (a == 3) ? 16'hBEEF : (a == 7) ? 16'h1234 : 16'h0000;
            load_check(0, AW'(a), e, $sformatf("sweep_a%0d", a));
        end

        // req_valid held high: alternate store 0x0001 / load at addr 0.
        pulses = 0;
        loads  = 0;
        v[0] = 1'b1; we[0] = 1'b1; addr[0] = 6'd0; wd[0] = 16'h0001;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rvld[0]) begin
                pulses++;
                if (!wasw[0]) begin
                    loads++;
                    check("held_load_rdata", rd[0], 16'h0001);
                end
                we[0] = ~we[0];
            end
        end
        v[0] = 1'b0;
        check("held_pulses", pulses, 4);
        check("held_loads", loads, 2);
        tick();

        // Reset in the first WAIT cycle of a store: no response, store lost.
        v[0] = 1'b1; we[0] = 1'b1; addr[0] = 6'd2; wd[0] = 16'hAAAA;
        tick();
        v[0] = 1'b0;
        rst  = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mid_rst_busy", busy[0], 0);
            check("mid_rst_valid", rvld[0], 0);
        end
        tick();
        load_check(0, 6'd2, 16'h0000, "mid_rst_ld2");
        load_check(0, 6'd3, 16'h0000, "mid_rst_ld3");

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

endmodule
